// File: rtl/calc_display.sv
`default_nettype none
// ============================================================================
// Module      : calc_display
// Description : Frame-buffered 8-digit BCD capture with multiplexed
//               active-low seven-segment scan, error and busy indication.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_display #(
    parameter int REFRESH_CNT = 100000,
    parameter int CNT_W       = 17
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] data,
    input  logic [3:0] pos,
    output logic [7:0] a_n,
    output logic [7:0] seg_n
);

    localparam logic [1:0]       c_st_error = 2'b00;
    localparam logic [1:0]       c_st_busy  = 2'b01;
    localparam logic [1:0]       c_st_print = 2'b11;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(REFRESH_CNT - 1);

    logic [7:0][3:0] r_shadow;
    logic [7:0][3:0] r_bank;
    logic [7:0]      r_mask;
    logic            r_err;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]      r_scan;
    logic [7:0]      r_an;
    logic [7:0]      r_seg;

    logic       w_capture;
    logic       w_commit;
    logic [3:0] w_pos_m1;
    logic [2:0] w_idx;
    logic [7:0] w_mask_nxt;
    logic [3:0] w_digit;
    logic       w_lead_zero;
    logic [7:0] w_glyph;
    logic [7:0] w_seg_nxt;

    assign w_capture = (status == c_st_print) && (pos >= 4'd1) && (pos <= 4'd8);
    assign w_commit  = (r_mask == 8'hFF);
    assign w_pos_m1  = pos - 4'd1;
    assign w_idx     = w_pos_m1[2:0];

    // A commit or any non-printing status drops the partial mask; a capture
    // landing in the commit cycle starts the next frame's mask afresh.
    always_comb begin
        w_mask_nxt = (w_commit || (status != c_st_print)) ? 8'h00 : r_mask;
        if (w_capture) begin
            w_mask_nxt[w_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_shadow <= '0;
            r_bank   <= '0;
            r_mask   <= '0;
        end else begin
            if (w_commit) begin
                r_bank <= r_shadow;
            end
            if (w_capture) begin
                r_shadow[w_idx] <= data;
            end
            r_mask <= w_mask_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (status == c_st_error) begin
            r_err <= 1'b1;
        end else if (w_commit) begin
            r_err <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_scan <= 3'd0;
        end else if (r_cnt == c_cnt_last) begin
            r_cnt  <= '0;
            r_scan <= r_scan + 3'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_digit     = r_bank[r_scan];
        w_lead_zero = (r_scan != 3'd0);
        for (int j = 0; j < 8; j++) begin
            if ((3'(j) >= r_scan) && (r_bank[j] != 4'd0)) begin
                w_lead_zero = 1'b0;
            end
        end
        case (w_digit)
            4'd0:    w_glyph = 8'hC0;
            4'd1:    w_glyph = 8'hF9;
            4'd2:    w_glyph = 8'hA4;
            4'd3:    w_glyph = 8'hB0;
            4'd4:    w_glyph = 8'h99;
            4'd5:    w_glyph = 8'h92;
            4'd6:    w_glyph = 8'h82;
            4'd7:    w_glyph = 8'hF8;
            4'd8:    w_glyph = 8'h80;
            4'd9:    w_glyph = 8'h90;
            default: w_glyph = 8'hBF;
        endcase
        if (r_err) begin
            case (r_scan)
                3'd2:       w_seg_nxt = 8'h86;
                3'd1, 3'd0: w_seg_nxt = 8'hAF;
                default:    w_seg_nxt = 8'hFF;
            endcase
        end else if (w_lead_zero) begin
            w_seg_nxt = 8'hFF;
        end else begin
            w_seg_nxt = w_glyph;
        end
        if (!r_err && (status == c_st_busy) && (r_scan == 3'd0)) begin
            w_seg_nxt[7] = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_an  <= 8'hFF;
            r_seg <= 8'hFF;
        end else begin
            r_an  <= ~(8'd1 << r_scan);
            r_seg <= w_seg_nxt;
        end
    end

    assign a_n   = r_an;
    assign seg_n = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_calc_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_display
// Description : Randomised self-checking bench for calc_display against a
//               digit-level display model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_display;

    localparam int REFRESH_CNT = 4;
    localparam int CNT_W       = 2;

    logic       clock  = 1'b0;
    logic       reset  = 1'b0;
    logic [1:0] status = 2'b10;
    logic [3:0] data   = 4'd0;
    logic [3:0] pos    = 4'd0;
    logic [7:0] a_n;
    logic [7:0] seg_n;

    calc_display #(
        .REFRESH_CNT(REFRESH_CNT),
        .CNT_W      (CNT_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .status(status),
        .data  (data),
        .pos   (pos),
        .a_n   (a_n),
        .seg_n (seg_n)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int edges  = 0;
    int bank_m [8];
    int frame  [8];
    bit err_m  = 1'b0;
    bit busy_m = 1'b0;

    function automatic logic [7:0] glyph(input int d);
        case (d)
            0:       return 8'hC0;
            1:       return 8'hF9;
            2:       return 8'hA4;
            3:       return 8'hB0;
            4:       return 8'h99;
            5:       return 8'h92;
            6:       return 8'h82;
            7:       return 8'hF8;
            8:       return 8'h80;
            9:       return 8'h90;
            default: return 8'hBF;
        endcase
    endfunction

    // Displayed number's most significant nonzero digit bounds what is lit.
    function automatic logic [7:0] exp_seg(input int s);
        logic [7:0] g;
        int top;
        if (err_m) begin
            if (s == 2) return 8'h86;
            if (s < 2)  return 8'hAF;
            return 8'hFF;
        end
        top = 0;
        for (int i = 0; i < 8; i++) if (bank_m[i] != 0) top = i;
        g = (s > top) ? 8'hFF : glyph(bank_m[s]);
        if (busy_m && s == 0) g[7] = 1'b0;
        return g;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input bit chk_seg);
        int s;
        logic [7:0] sel;
        @(posedge clock);
        edges++;
        #1;
        s   = ((edges - 1) / 4) % 8;
        sel = 8'd1 << s;
        check("a_n", a_n, ~sel);
        if (chk_seg) check($sformatf("seg_n[%0d]", s), seg_n, exp_seg(s));
    endtask

    task automatic window(input int n);
        repeat (n) tick(1'b1);
    endtask

    task automatic settle();
        tick(1'b0);
        tick(1'b0);
    endtask

    task automatic set_idle(input bit busy);
        status = busy ? 2'b01 : 2'b10;
        pos    = 4'd0;
        busy_m = busy;
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int p = lo; p <= hi; p++) begin
            status = 2'b11;
            pos    = 4'(p);
            data   = 4'(frame[p-1]);
            tick(1'b0);
        end
        set_idle(1'b0);
        settle();
    endtask

    task automatic send_frame(input bit shuffle, input bit junk);
        int order [8];
        int j;
        int t;
        for (int i = 0; i < 8; i++) order[i] = i;
        if (shuffle) begin
            for (int i = 7; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = order[i]; order[i] = order[j]; order[j] = t;
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (junk && $urandom_range(0, 3) == 0) begin
                status = 2'b11;
                pos    = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
                data   = 4'($urandom_range(0, 15));
                tick(1'b0);
            end
            status = 2'b11;
            pos    = 4'(order[i] + 1);
            data   = 4'(frame[order[i]]);
            tick(1'b0);
        end
        set_idle(1'b0);
        settle();
        for (int i = 0; i < 8; i++) bank_m[i] = frame[i];
        err_m = 1'b0;
    endtask

    task automatic release_reset();
        #3;
        reset = 1'b1;
        edges = 0;
        for (int i = 0; i < 8; i++) bank_m[i] = 0;
        err_m  = 1'b0;
        busy_m = 1'b0;
    endtask

    initial begin
        int nd;
        for (int i = 0; i < 8; i++) bank_m[i] = 0;

        // Power-on reset and first edge after release
        repeat (2) @(posedge clock);
        #1;
        check("reset a_n", a_n, 8'hFF);
        check("reset seg_n", seg_n, 8'hFF);
        release_reset();
        tick(1'b1);
        window(31);

        // 00001234 in order, then all zeros
        frame = '{4, 3, 2, 1, 0, 0, 0, 0};
        send_frame(1'b0, 1'b0);
        window(32);
        frame = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(1'b1, 1'b0);
        window(32);

        // Partial frames abort and must not combine into a commit
        frame = '{9, 9, 9, 9, 9, 9, 9, 9};
        send_range(1, 5);
        window(32);
        send_range(6, 8);
        window(32);

        // Error pulse, busy masked by error, cleared by the next frame
        status = 2'b00;
        tick(1'b0);
        set_idle(1'b0);
        err_m = 1'b1;
        settle();
        window(32);
        set_idle(1'b1);
        window(32);
        frame = '{7, 0, 0, 0, 0, 0, 0, 0};
        send_frame(1'b1, 1'b1);
        window(32);
        set_idle(1'b1);
        window(32);

        // Randomised frames
        repeat (8) begin
            nd = $urandom_range(0, 8);
            for (int i = 0; i < 8; i++) begin
                if (i < nd)
                    frame[i] = ($urandom_range(0, 5) == 0) ? $urandom_range(10, 15)
                                                           : $urandom_range(0, 9);
                else
                    frame[i] = 0;
            end
            send_frame(1'b1, 1'b1);
            set_idle(1'($urandom_range(0, 1)));
            window(32);
        end

        // Asynchronous reset in the middle of a capture
        frame = '{1, 2, 3, 4, 5, 6, 7, 8};
        for (int p = 1; p <= 3; p++) begin
            status = 2'b11;
            pos    = 4'(p);
            data   = 4'(frame[p-1]);
            tick(1'b0);
        end
        pos  = 4'd4;
        data = 4'd4;
        #2;
        reset = 1'b0;
        #1;
        check("mid-reset a_n", a_n, 8'hFF);
        check("mid-reset seg_n", seg_n, 8'hFF);
        status = 2'b10;
        pos    = 4'd0;
        repeat (2) @(posedge clock);
        #1;
        check("held-reset a_n", a_n, 8'hFF);
        check("held-reset seg_n", seg_n, 8'hFF);
        release_reset();
        tick(1'b1);
        window(31);
        send_range(5, 8);
        window(32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
